// File: rtl/mem_access.sv
// Memory stage: drives the data bus with a req/ack handshake, aligns and extends load data,
// and registers the writeback result into the mem_wb boundary.
//
// Ports:
//   clk_i, rst_i              clock, async active-high reset
//   reg_*_i                   register-write fields from exe_mem
//   mem_we_i, mem_addr_i      store flag and byte address
//   mem_data_i, mem_op_i      store data and access code
//   dbus_*                    data bus (req/ack handshake, ack carries rdata)
//   stallreq_o                stall request while an access is outstanding
//   wb_reg_*_o                registered writeback fields (mem_wb)
//   misalign_o, bus_err_o     registered one-cycle error pulses
module mem_access #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4:0]            reg_waddr_i,
  input  logic                  reg_we_i,
  input  logic [DATA_WIDTH-1:0] reg_wdata_i,
  input  logic                  mem_we_i,
  input  logic [DATA_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic [3:0]            mem_op_i,
  output logic                  dbus_req_o,
  output logic                  dbus_we_o,
  output logic [DATA_WIDTH-1:0] dbus_addr_o,
  output logic [3:0]            dbus_be_o,
  output logic [DATA_WIDTH-1:0] dbus_wdata_o,
  input  logic                  dbus_ack_i,
  input  logic [DATA_WIDTH-1:0] dbus_rdata_i,
  output logic                  stallreq_o,
  output logic [4:0]            wb_reg_waddr_o,
  output logic                  wb_reg_we_o,
  output logic [DATA_WIDTH-1:0] wb_reg_wdata_o,
  output logic                  misalign_o,
  output logic                  bus_err_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t state;
  logic [7:0] cnt;

  logic is_load;
  logic is_store;
  logic sz_b;
  logic sz_h;
  logic sz_w;
  logic sext;
  logic [1:0] ofs;
  logic aligned;
  logic acc_ok;
  logic misal;
  logic busy;
  logic req;
  logic done;
  logic tmo;
  logic stall;
  logic [3:0] be;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] ld_data;

  assign ofs = mem_addr_i[1:0];

  // Access-code decode; codes 9..15 fall to the default and act as NOP.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sz_b     = 1'b0;
    sz_h     = 1'b0;
    sz_w     = 1'b0;
    sext     = 1'b0;
    unique case (1'b1)
      (mem_op_i == OP_LB): begin
        is_load = 1'b1;
        sz_b    = 1'b1;
        sext    = 1'b1;
      end
      (mem_op_i == OP_LH): begin
        is_load = 1'b1;
        sz_h    = 1'b1;
        sext    = 1'b1;
      end
      (mem_op_i == OP_LW): begin
        is_load = 1'b1;
        sz_w    = 1'b1;
      end
      (mem_op_i == OP_LBU): begin
        is_load = 1'b1;
        sz_b    = 1'b1;
      end
      (mem_op_i == OP_LHU): begin
        is_load = 1'b1;
        sz_h    = 1'b1;
      end
      (mem_op_i == OP_SB): begin
        is_store = 1'b1;
        sz_b     = 1'b1;
      end
      (mem_op_i == OP_SH): begin
        is_store = 1'b1;
        sz_h     = 1'b1;
      end
      (mem_op_i == OP_SW): begin
        is_store = 1'b1;
        sz_w     = 1'b1;
      end
      default: ;
    endcase
  end

  // Byte enables and lane-replicated store data.
  always_comb begin
    be = 4'b0000;
    wd = '0;
    unique case (1'b1)
      sz_b: begin
        be = 4'b0001 << ofs;
        wd = {4{mem_data_i[7:0]}};
      end
      sz_h: begin
        be = 4'b0011 << ofs;
        wd = {2{mem_data_i[15:0]}};
      end
      sz_w: begin
        be = 4'b1111;
        wd = mem_data_i;
      end
      default: ;
    endcase
  end

  assign aligned = sz_h ? ~ofs[0] :
                   sz_w ? (ofs == 2'b00) : 1'b1;

  assign acc_ok = (is_load | is_store) & aligned;
  assign misal  = (is_load | is_store) & ~aligned;
  assign busy   = (state == WAIT);

  // Request is combinational so a zero-wait slave can ack in the same cycle.
  assign req  = ~rst_i & (busy | acc_ok);
  assign done = req & dbus_ack_i;
  assign tmo  = busy & ~dbus_ack_i & (cnt == TMO);

  // The timeout cycle releases the pipeline so the aborted op can retire.
  assign stall = req & ~dbus_ack_i & ~tmo;

  assign dbus_req_o   = req;
  assign dbus_we_o    = req & is_store;
  assign dbus_addr_o  = req ? {mem_addr_i[DATA_WIDTH-1:2], 2'b00} : '0;
  assign dbus_be_o    = req ? be : 4'b0000;
  assign dbus_wdata_o = (req & is_store) ? wd : '0;
  assign stallreq_o   = stall;

  // Load lane extraction and extension.
  assign lane = dbus_rdata_i >> {ofs, 3'b000};

  always_comb begin
    ld_data = lane;
    unique case (1'b1)
      sz_b: ld_data = {{(DATA_WIDTH-8){sext & lane[7]}}, lane[7:0]};
      sz_h: ld_data = {{(DATA_WIDTH-16){sext & lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      cnt            <= 8'd0;
      wb_reg_waddr_o <= 5'd0;
      wb_reg_we_o    <= 1'b0;
      wb_reg_wdata_o <= '0;
      misalign_o     <= 1'b0;
      bus_err_o      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc_ok && !dbus_ack_i) begin
            state <= WAIT;
            cnt   <= 8'd1;
          end
        end
        WAIT: begin
          if (dbus_ack_i || tmo) begin
            state <= IDLE;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (stall) begin
        // Bubble: address and data hold, only the qualifiers clear.
        wb_reg_we_o <= 1'b0;
        misalign_o  <= 1'b0;
        bus_err_o   <= 1'b0;
      end else begin
        wb_reg_waddr_o <= reg_waddr_i;
        wb_reg_we_o    <= reg_we_i;
        wb_reg_wdata_o <= reg_wdata_i;
        misalign_o     <= 1'b0;
        bus_err_o      <= 1'b0;
        if (tmo) begin
          wb_reg_we_o <= 1'b0;
          bus_err_o   <= 1'b1;
        end else if (misal) begin
          wb_reg_we_o <= 1'b0;
          misalign_o  <= 1'b1;
        end else if (done && is_load) begin
          wb_reg_wdata_o <= ld_data;
        end else if (done && is_store) begin
          wb_reg_we_o <= 1'b0;
        end
      end
    end
  end

  // Direction comes from mem_op_i; the separate store flag is redundant.
  logic unused;
  assign unused = mem_we_i;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, loads, stores, wait states,
// misalignment, timeout and asynchronous reset.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  reg_waddr;
  logic        reg_we;
  logic [31:0] reg_wdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_op;
  logic        req;
  logic        bwe;
  logic [31:0] baddr;
  logic [3:0]  be;
  logic [31:0] bwdata;
  logic        ack;
  logic [31:0] rdata;
  logic        stall;
  logic [4:0]  wb_waddr;
  logic        wb_we;
  logic [31:0] wb_wdata;
  logic        misal;
  logic        berr;

  int nchk = 0;
  int nerr = 0;

  mem_access #(.DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .reg_waddr_i    (reg_waddr),
    .reg_we_i       (reg_we),
    .reg_wdata_i    (reg_wdata),
    .mem_we_i       (mem_we),
    .mem_addr_i     (mem_addr),
    .mem_data_i     (mem_data),
    .mem_op_i       (mem_op),
    .dbus_req_o     (req),
    .dbus_we_o      (bwe),
    .dbus_addr_o    (baddr),
    .dbus_be_o      (be),
    .dbus_wdata_o   (bwdata),
    .dbus_ack_i     (ack),
    .dbus_rdata_i   (rdata),
    .stallreq_o     (stall),
    .wb_reg_waddr_o (wb_waddr),
    .wb_reg_we_o    (wb_we),
    .wb_reg_wdata_o (wb_wdata),
    .misalign_o     (misal),
    .bus_err_o      (berr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic [3:0] op, input logic [31:0] addr,
                     input logic [31:0] data, input logic a,
                     input logic [31:0] rd, input logic [4:0] wa,
                     input logic we, input logic [31:0] wdat);
    mem_op    = op;
    mem_addr  = addr;
    mem_data  = data;
    mem_we    = (op >= 4'd6 && op <= 4'd8);
    ack       = a;
    rdata     = rd;
    reg_waddr = wa;
    reg_we    = we;
    reg_wdata = wdat;
  endtask

  task automatic edge_wb();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] rd;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t lv[5];

  initial begin
    lv[0] = '{4'd2, 32'h12, 32'h8001_0000, 32'hFFFF_8001};
    lv[1] = '{4'd4, 32'h11, 32'h0000_9A00, 32'h0000_009A};
    lv[2] = '{4'd5, 32'h10, 32'h1234_F00D, 32'h0000_F00D};
    lv[3] = '{4'd3, 32'h14, 32'hCAFE_F00D, 32'hCAFE_F00D};
    lv[4] = '{4'd1, 32'h102, 32'h0055_0000, 32'h0000_0055};

    rst = 1'b1;
    drv(4'd0, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    #12;
    chk("rst_req", {31'b0, req}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_wb_we", {31'b0, wb_we}, 32'd0);
    chk("rst_wb_data", wb_wdata, 32'd0);
    chk("rst_flags", {30'b0, misal, berr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ALU pass-through
    @(negedge clk);
    drv(4'd0, 32'h0, 32'h0, 1'b0, 32'h0, 5'd5, 1'b1, 32'h1234);
    #1;
    chk("alu_req", {31'b0, req}, 32'd0);
    chk("alu_stall", {31'b0, stall}, 32'd0);
    chk("alu_bus_be", {28'b0, be}, 32'd0);
    edge_wb();
    chk("alu_waddr", {27'b0, wb_waddr}, 32'd5);
    chk("alu_we", {31'b0, wb_we}, 32'd1);
    chk("alu_wdata", wb_wdata, 32'h1234);

    // LB sign extend, zero wait
    @(negedge clk);
    drv(4'd1, 32'h103, 32'h0, 1'b1, 32'h80AA_BBCC, 5'd7, 1'b1, 32'h0);
    #1;
    chk("lb_req", {31'b0, req}, 32'd1);
    chk("lb_addr", baddr, 32'h100);
    chk("lb_be", {28'b0, be}, 32'h8);
    chk("lb_we", {31'b0, bwe}, 32'd0);
    chk("lb_stall", {31'b0, stall}, 32'd0);
    edge_wb();
    chk("lb_wdata", wb_wdata, 32'hFFFF_FF80);
    chk("lb_wb_we", {31'b0, wb_we}, 32'd1);
    chk("lb_waddr", {27'b0, wb_waddr}, 32'd7);

    // Zero-wait load table
    foreach (lv[i]) begin
      @(negedge clk);
      drv(lv[i].op, lv[i].addr, 32'h0, 1'b1, lv[i].rd, 5'd9, 1'b1, 32'h0);
      #1;
      chk($sformatf("ld%0d_stall", i), {31'b0, stall}, 32'd0);
      edge_wb();
      chk($sformatf("ld%0d_data", i), wb_wdata, lv[i].exp);
    end

    // SB / SW zero wait
    @(negedge clk);
    drv(4'd6, 32'h1, 32'h1234_56A5, 1'b1, 32'h0, 5'd3, 1'b1, 32'h0);
    #1;
    chk("sb_be", {28'b0, be}, 32'h2);
    chk("sb_wdata", bwdata, 32'hA5A5_A5A5);
    chk("sb_we", {31'b0, bwe}, 32'd1);
    edge_wb();
    chk("sb_wb_we", {31'b0, wb_we}, 32'd0);
    @(negedge clk);
    drv(4'd8, 32'h8, 32'h1122_3344, 1'b1, 32'h0, 5'd3, 1'b1, 32'h0);
    #1;
    chk("sw_be", {28'b0, be}, 32'hF);
    chk("sw_wdata", bwdata, 32'h1122_3344);
    chk("sw_addr", baddr, 32'h8);

    // SH with 3 wait states
    @(negedge clk);
    drv(4'd7, 32'h202, 32'h0000_BEEF, 1'b0, 32'h0, 5'd4, 1'b1, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("sh_stall%0d", c), {31'b0, stall}, 32'd1);
      chk($sformatf("sh_be%0d", c), {28'b0, be}, 32'hC);
      chk($sformatf("sh_wd%0d", c), bwdata, 32'hBEEF_BEEF);
      edge_wb();
      chk($sformatf("sh_bub%0d", c), {31'b0, wb_we}, 32'd0);
      @(negedge clk);
    end
    ack = 1'b1;
    #1;
    chk("sh_ack_stall", {31'b0, stall}, 32'd0);
    chk("sh_ack_req", {31'b0, req}, 32'd1);
    chk("sh_ack_addr", baddr, 32'h200);
    edge_wb();
    chk("sh_wb_we", {31'b0, wb_we}, 32'd0);
    @(negedge clk);
    drv(4'd0, 32'h0, 32'h0, 1'b0, 32'h0, 5'd6, 1'b1, 32'h66);
    #1;
    chk("sh_idle_req", {31'b0, req}, 32'd0);
    edge_wb();
    chk("sh_after", wb_wdata, 32'h66);

    // LHU misaligned
    @(negedge clk);
    drv(4'd5, 32'h301, 32'h0, 1'b0, 32'h0, 5'd8, 1'b1, 32'h0);
    #1;
    chk("mis_req", {31'b0, req}, 32'd0);
    chk("mis_stall", {31'b0, stall}, 32'd0);
    chk("mis_addr", baddr, 32'd0);
    edge_wb();
    chk("mis_flag", {31'b0, misal}, 32'd1);
    chk("mis_we", {31'b0, wb_we}, 32'd0);
    @(negedge clk);
    drv(4'd0, 32'h0, 32'h0, 1'b0, 32'h0, 5'd8, 1'b1, 32'h77);
    edge_wb();
    chk("mis_clear", {31'b0, misal}, 32'd0);
    chk("mis_nop_we", {31'b0, wb_we}, 32'd1);

    // Timeout, TIMEOUT=4
    @(negedge clk);
    drv(4'd3, 32'h400, 32'h0, 1'b0, 32'h0, 5'd10, 1'b1, 32'h0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("tmo_stall%0d", c), {31'b0, stall}, 32'd1);
      edge_wb();
      chk($sformatf("tmo_err%0d", c), {31'b0, berr}, 32'd0);
      @(negedge clk);
    end
    #1;
    chk("tmo_last_stall", {31'b0, stall}, 32'd0);
    chk("tmo_last_req", {31'b0, req}, 32'd1);
    edge_wb();
    chk("tmo_err", {31'b0, berr}, 32'd1);
    chk("tmo_we", {31'b0, wb_we}, 32'd0);
    @(negedge clk);
    drv(4'd0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, 5'd11, 1'b1, 32'h99);
    #1;
    chk("late_req", {31'b0, req}, 32'd0);
    chk("late_stall", {31'b0, stall}, 32'd0);
    chk("late_be", {28'b0, be}, 32'd0);
    edge_wb();
    chk("late_err", {31'b0, berr}, 32'd0);
    chk("late_wdata", wb_wdata, 32'h99);

    // Reset mid-WAIT
    @(negedge clk);
    drv(4'd3, 32'h500, 32'h0, 1'b0, 32'h0, 5'd12, 1'b1, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_req", {31'b0, req}, 32'd0);
    chk("mrst_stall", {31'b0, stall}, 32'd0);
    chk("mrst_waddr", {27'b0, wb_waddr}, 32'd0);
    chk("mrst_wdata", wb_wdata, 32'd0);
    chk("mrst_we", {31'b0, wb_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drv(4'd3, 32'h500, 32'h0, 1'b1, 32'hDEAD_BEEF, 5'd13, 1'b1, 32'h0);
    #1;
    chk("post_req", {31'b0, req}, 32'd1);
    chk("post_stall", {31'b0, stall}, 32'd0);
    chk("post_addr", baddr, 32'h500);
    chk("post_be", {28'b0, be}, 32'hF);
    edge_wb();
    chk("post_wdata", wb_wdata, 32'hDEAD_BEEF);
    chk("post_we", {31'b0, wb_we}, 32'd1);
    chk("post_waddr", {27'b0, wb_waddr}, 32'd13);
    @(negedge clk);
    drv(4'd0, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage of the 5-stage RV32I core. Sits directly downstream of the execute stage's exe_mem register.
- Consumes the register-write and memory-request fields produced by execute, runs load/store transactions on the data bus using a req/ack handshake, and aligns and extends load data.
- Registers the writeback result into the mem_wb boundary.
- Requests a pipeline stall from pipe_ctrl while a bus access is outstanding.

Parameters:
- DATA_WIDTH, 32, datapath and address width. Only 32 is supported.
- TIMEOUT, 255, maximum number of WAIT cycles without ack before the access is aborted. Range 1..255.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous reset, active-high
- reg_waddr_i  in  5  destination register from exe_mem
- reg_we_i  in  1  register write enable from exe_mem
- reg_wdata_i  in  32  ALU / link result from exe_mem
- mem_we_i  in  1  store indicator from exe_mem
- mem_addr_i  in  32  byte address
- mem_data_i  in  32  store data (rs2, unaligned)
- mem_op_i  in  4  access code: NOP=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8
- dbus_req_o  out  1  bus request
- dbus_we_o  out  1  bus write
- dbus_addr_o  out  32  word address, bits [1:0] forced to 0
- dbus_be_o  out  4  byte enables
- dbus_wdata_o  out  32  lane-replicated store data
- dbus_ack_i  in  1  bus completion; read data is valid in the same cycle
- dbus_rdata_i  in  32  read data
- stallreq_o  out  1  stall request to pipe_ctrl
- wb_reg_waddr_o  out  5  registered destination register
- wb_reg_we_o  out  1  registered write enable
- wb_reg_wdata_o  out  32  registered writeback data
- misalign_o  out  1  registered one-cycle misaligned-access flag
- bus_err_o  out  1  registered one-cycle timeout flag

Behaviour:
- Reset, asynchronous: state=IDLE, timeout counter=0, all wb_* outputs=0, misalign_o=0, bus_err_o=0. dbus_req_o and stallreq_o drop immediately. Reset mid-transaction abandons the access; a later ack is ignored.
- Access valid: mem_op_i is in 1..8 and the access is aligned.
  - Aligned means: halfword ops require addr[0]=0; word ops require addr[1:0]=0.
  - Other codes 9..15 are treated as NOP.
- Store lanes, with a=addr[1:0]:
  - SB: be=4'b0001<<a, wdata={4{data[7:0]}}.
  - SH: be=4'b0011<<a, wdata={2{data[15:0]}}.
  - SW: be=4'hF, wdata=data.
  - Loads: be follows the same pattern, dbus_we_o=0.
- Load extract: lane = rdata>>(8*a).
  - LB / LH sign-extend bits 7 / 15.
  - LBU / LHU zero-extend.
  - LW passes the word through.
- FSM states: IDLE, WAIT.
  - IDLE, access valid: dbus_req_o=1 combinationally in the same cycle.
    - If dbus_ack_i=1 that cycle (zero wait states): the access completes, no stall, state stays IDLE.
    - Otherwise: stallreq_o=1, go to WAIT, counter=1.
  - WAIT: dbus_req_o=1, and the bus outputs are held from the inputs. Upstream is stalled, so the inputs are stable.
    - ack: the access completes, stallreq_o=0 that cycle, go to IDLE.
    - No ack and counter==TIMEOUT: drop req next cycle, stallreq_o=0, go to IDLE, bus_err_o=1 for one cycle, register write suppressed.
    - Otherwise: counter+1, stallreq_o=1.
  - dbus_ack_i while req=0 is ignored.
- Misaligned access: no bus request, no stall. The next edge loads wb_reg_we_o=0 and misalign_o=1 for one cycle.
- wb register update on every clock edge:
  - stallreq_o=1: bubble (wb_reg_we_o=0, misalign_o=0, bus_err_o=0).
  - Completed load: waddr, we=reg_we_i, wdata=extracted load data.
  - Completed store: we=0.
  - NOP: pass reg_waddr_i / reg_we_i / reg_wdata_i through.
- Latency: non-memory ops take 1 cycle. Memory ops take 1 cycle plus the number of wait cycles.
- Bus outputs are 0 whenever dbus_req_o=0.

Test Plan:
- ALU pass-through: mem_op_i=0, reg_waddr_i=5, reg_we_i=1, reg_wdata_i=0x1234 → next edge gives wb_reg_waddr_o=5, wb_reg_we_o=1, wb_reg_wdata_o=0x1234. req and stall stay 0.
- LB sign extend, zero wait: mem_op_i=LB, addr=0x103, ack the same cycle with rdata=0x80AABBCC → dbus_addr_o=0x100, be=4'b1000, no stall, wb_reg_wdata_o=0xFFFFFF80.
- SH with 3 wait states: addr=0x202, data=0x0000BEEF, ack in the 4th cycle → be=4'b1100, wdata=0xBEEFBEEF, stallreq_o=1 for 3 cycles then 0 in the ack cycle, wb_reg_we_o=0.
- LHU misaligned: addr=0x301 → no req, no stall, misalign_o pulses 1 cycle, wb_reg_we_o=0.
- Timeout with TIMEOUT=4: LW with no ack → stall for 4 cycles, then req drops, bus_err_o pulses, wb_reg_we_o=0. A late ack is ignored.
- Reset mid-WAIT: assert rst_i during the 2nd wait cycle → dbus_req_o, stallreq_o and all wb_* outputs go to 0 asynchronously. After release, a new LW with zero-wait ack completes normally.
